vga_sync_gen: RTL and testbench

- Generates VGA raster timing: horizontal/vertical counters, sync pulses, visible-area flag and current pixel coordinates.
- Supplies the video_on and pix_x/pix_y inputs that the pixel-colour generator (graphics) consumes.
- Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate derived from the 100 MHz system clock by a tick divider.
- All timing values are parameters, so the bench can run reduced rasters.

---
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, registered sync pulses, visible-area flag and line/frame ticks.
// Sync outputs are computed from the next-state counters so they switch on
// the same clock edge as pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_START  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  HS_END    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_START  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  // Display limits kept one bit wider so a 1024-wide visible area still compares correctly.
  localparam logic [10:0] H_VIS     = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS     = 11'(V_DISPLAY);
  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic        SYNC_ACT  = 1'(SYNC_POL);

  logic [3:0] r_div;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_p_tick;
  logic       w_h_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hs_act;
  logic       w_vs_act;

  // With CLK_DIV = 1 the divider sits at 0 and the tick stays high every cycle.
  assign w_p_tick = (r_div == DIV_LAST);
  assign w_h_wrap = (r_h == H_LAST);

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_p_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  // Next-state raster position; shared by the counters and the sync decode.
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_p_tick) begin
      if (w_h_wrap) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
  end

  // Sync windows decoded on the upcoming position so the registered pulse lines up with the counters.
  always_comb begin
    w_hs_act = (w_h_next >= HS_START) && (w_h_next <= HS_END);
    w_vs_act = (w_v_next >= VS_START) && (w_v_next <= VS_END);
  end

  // Raster counters and sync registers advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_hsync <= ~SYNC_ACT;
      r_vsync <= ~SYNC_ACT;
    end else begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      r_hsync <= w_hs_act ? SYNC_ACT : ~SYNC_ACT;
      r_vsync <= w_vs_act ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign p_tick     = w_p_tick;
  assign pixel_x    = r_h;
  assign pixel_y    = r_v;
  assign video_on   = ({1'b0, r_h} < H_VIS) && ({1'b0, r_v} < V_VIS);
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign line_tick  = w_p_tick && w_h_wrap;
  assign frame_tick = w_p_tick && w_h_wrap && (r_v == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Bench for vga_sync_gen: two reduced rasters (CLK_DIV 1 active-high sync,
// CLK_DIV 4 active-low sync) checked every cycle against an arithmetic
// model of the raster position derived from the clock count since reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  always #5 clk = ~clk;

  logic       a_p_tick, a_video_on, a_hsync, a_vsync, a_line_tick, a_frame_tick;
  logic [9:0] a_x, a_y;
  logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_line_tick, b_frame_tick;
  logic [9:0] b_x, b_y;

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .SYNC_POL(1)
  ) dut_a (
    .clk(clk), .reset(reset), .p_tick(a_p_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_video_on), .hsync(a_hsync), .vsync(a_vsync),
    .line_tick(a_line_tick), .frame_tick(a_frame_tick)
  );

  vga_sync_gen #(
    .H_DISPLAY(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(4), .SYNC_POL(0)
  ) dut_b (
    .clk(clk), .reset(reset), .p_tick(b_p_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_video_on), .hsync(b_hsync), .vsync(b_vsync),
    .line_tick(b_line_tick), .frame_tick(b_frame_tick)
  );

  // Expected outputs after n clock edges since reset release.
  // Packing: [25:16] y, [15:6] x, [5] p_tick, [4] video_on, [3] hsync, [2] vsync, [1] line_tick, [0] frame_tick
  function automatic logic [25:0] model(input int inst, input int cnt);
    int hd, hf, hs, hb, vd, vf, vs, vb, d, pol;
    int ht, vt, p, x, y;
    logic pt, vo, hsv, vsv, lt, ft;
    if (inst == 0) begin
      hd = 8; hf = 2; hs = 3; hb = 2; vd = 4; vf = 1; vs = 1; vb = 1; d = 1; pol = 1;
    end else begin
      hd = 5; hf = 1; hs = 2; hb = 2; vd = 3; vf = 1; vs = 1; vb = 1; d = 4; pol = 0;
    end
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    p   = cnt / d;
    x   = p % ht;
    y   = (p / ht) % vt;
    pt  = ((cnt % d) == d - 1);
    vo  = (x < hd) && (y < vd);
    hsv = ((x >= hd + hf) && (x < hd + hf + hs)) ? pol[0] : !pol[0];
    vsv = ((y >= vd + vf) && (y < vd + vf + vs)) ? pol[0] : !pol[0];
    lt  = pt && (x == ht - 1);
    ft  = lt && (y == vt - 1);
    return {10'(y), 10'(x), pt, vo, hsv, vsv, lt, ft};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  task automatic check_all();
    logic [25:0] ma, mb;
    ma = model(0, n);
    mb = model(1, n);
    check("a_xy", {a_y, a_x}, ma[25:6]);
    check("a_flags", {a_video_on, a_hsync, a_vsync, a_line_tick, a_frame_tick}, ma[4:0]);
    // With CLK_DIV 1 the tick is a pure decode of the idle divider, so it is only checked when running.
    if (!reset) check("a_ptick", a_p_tick, ma[5]);
    check("b_xy", {b_y, b_x}, mb[25:6]);
    check("b_flags", {b_p_tick, b_video_on, b_hsync, b_vsync, b_line_tick, b_frame_tick}, mb[5:0]);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) n++;
    @(negedge clk);
    check_all();
  endtask

  task automatic assert_reset_mid(input int ofs);
    @(posedge clk);
    #(ofs);
    reset = 1'b1;
    n = 0;
    #1;
    check_all();
    check("rst_a_sync", {a_hsync, a_vsync}, 2'b00);
    check("rst_b_sync", {b_hsync, b_vsync}, 2'b11);
  endtask

  task automatic release_reset(input int ofs);
    @(posedge clk);
    #(ofs);
    reset = 1'b0;
    n = 0;
  endtask

  initial begin
    int k;
    int a_vo, a_ft, b_vo, b_ft, b_lt, b_pt;

    #12;
    check_all();
    check("rst_xy", {a_x, a_y, b_x, b_y}, 40'd0);
    check("rst_vo", {a_video_on, b_video_on}, 2'b11);

    release_reset(3);
    k = 0;
    while (b_x == 10'd0 && k < 20) begin
      step();
      k++;
    end
    check("b_first_advance_edges", k, 4);

    a_vo = 0; a_ft = 0; b_vo = 0; b_ft = 0; b_lt = 0; b_pt = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (i < 210) begin
        a_vo += int'(a_video_on);
        a_ft += int'(a_frame_tick);
      end
      b_vo += int'(b_video_on);
      b_ft += int'(b_frame_tick);
      b_lt += int'(b_line_tick);
      b_pt += int'(b_p_tick);
    end
    check("a_video_on_per_2frames", a_vo, 64);
    check("a_frame_ticks_2frames", a_ft, 2);
    check("b_video_on_per_frame", b_vo, 60);
    check("b_frame_ticks", b_ft, 1);
    check("b_line_ticks", b_lt, 6);
    check("b_p_ticks", b_pt, 60);

    // Park raster A at (10, 5) where both syncs are active, then reset mid-cycle.
    k = 0;
    while ((n % 105) != 85 && k < 200) begin
      step();
      k++;
    end
    check("a_sync_point_reached", (n % 105), 85);
    check("a_both_syncs_active", {a_hsync, a_vsync}, 2'b11);
    assert_reset_mid(2);
    repeat (2) step();
    release_reset($urandom_range(1, 9));

    k = 0;
    while (b_x == 10'd0 && k < 20) begin
      step();
      k++;
    end
    check("b_restart_advance_edges", k, 4);

    repeat (8) begin
      repeat ($urandom_range(30, 500)) step();
      assert_reset_mid($urandom_range(1, 8));
      repeat ($urandom_range(0, 3)) step();
      release_reset($urandom_range(1, 9));
    end
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
